// File: rtl/cmd_fifo_sync.sv
// ---------------------------------------------------------------------------
// cmd_fifo_sync
//
// Single-clock command queue between the memory-controller front end and the
// DDR command scheduler. Each entry holds one command (type, address, burst
// count, write data, write byte mask). Storage is an inferred circular buffer
// with first-word-fall-through output, a registered occupancy level and an
// almost-full flag for upstream throttling.
//
// Parameters:
//   ADDR_W       command address width
//   BURST_W      burst count width
//   DATA_W       write data width (multiple of 8), mask width is DATA_W/8
//   DEPTH        number of entries (power of two, >= 2)
//   AFULL_THRESH level at or above which io_push_afull asserts (1..DEPTH)
//
// Ports:
//   clk, rstn               clock (rising edge), async active-low reset
//   io_push_valid/ready     producer handshake, push on valid && ready
//   io_push_cmd_type/addr/burst_cnt/wt_data/wt_mask   command to enqueue
//   io_push_afull           level >= AFULL_THRESH
//   io_pop_valid/ready      consumer handshake, pop on valid && ready
//   io_pop_cmd_type/addr/burst_cnt/wt_data/wt_mask    head command (0 if empty)
//   io_level                current entry count, 0..DEPTH
//
// Optional statistics (macro CMD_FIFO_SYNC_STAT_EN):
//   io_stat_clr             synchronous clear of both statistics
//   io_max_level            high-water mark of io_level
//   io_stall_cnt            saturating count of cycles with a refused push
// ---------------------------------------------------------------------------
module cmd_fifo_sync #(
  parameter int ADDR_W       = 27,
  parameter int BURST_W      = 6,
  parameter int DATA_W       = 128,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  localparam int MASK_W      = DATA_W / 8,
  localparam int LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               io_push_valid,
  output logic               io_push_ready,
  input  logic               io_push_cmd_type,
  input  logic [ADDR_W-1:0]  io_push_addr,
  input  logic [BURST_W-1:0] io_push_burst_cnt,
  input  logic [DATA_W-1:0]  io_push_wt_data,
  input  logic [MASK_W-1:0]  io_push_wt_mask,
  output logic               io_push_afull,
  input  logic               io_pop_valid,
  output logic               io_pop_ready,
  output logic               io_pop_cmd_type,
  output logic [ADDR_W-1:0]  io_pop_addr,
  output logic [BURST_W-1:0] io_pop_burst_cnt,
  output logic [DATA_W-1:0]  io_pop_wt_data,
  output logic [MASK_W-1:0]  io_pop_wt_mask,
  output logic [LVL_W-1:0]   io_level
`ifdef CMD_FIFO_SYNC_STAT_EN
  ,
  input  logic               io_stat_clr,
  output logic [LVL_W-1:0]   io_max_level,
  output logic [15:0]        io_stall_cnt
`endif
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = 1 + ADDR_W + BURST_W + DATA_W + MASK_W;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL_THRESH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;

  logic               full;
  logic               empty;
  logic               push_fire;
  logic               pop_fire;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Pointers carry one extra wrap bit: equal indices with differing wrap bits
  // means the writer has lapped the reader exactly once.
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Gating with rstn keeps both handshakes low while reset is held.
  assign io_push_ready = rstn && !full;
  assign io_pop_ready  = rstn && !empty;

  assign push_fire = io_push_valid && io_push_ready;
  assign pop_fire  = io_pop_valid && io_pop_ready;

  assign io_push_afull = (level_q >= AFULL_LVL);
  assign io_level      = level_q;

  assign push_entry = {io_push_cmd_type, io_push_addr, io_push_burst_cnt,
                       io_push_wt_data, io_push_wt_mask};

  // Head is presented combinationally from storage; forced to zero when empty
  // so stale memory contents never leak onto the pop fields.
  assign head_entry = io_pop_ready ? mem_q[rd_ptr_q[IDX_W-1:0]] : '0;

  assign {io_pop_cmd_type, io_pop_addr, io_pop_burst_cnt,
          io_pop_wt_data, io_pop_wt_mask} = head_entry;

  // Next-state for pointers and level. A push into a full queue is already
  // blocked by io_push_ready, so a simultaneous pop there only decrements.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_fire, pop_fire})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_entry;
  end

`ifdef CMD_FIFO_SYNC_STAT_EN
  logic [LVL_W-1:0] max_level_q, max_level_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;

  // High-water mark follows the level being loaded this cycle so it never
  // trails io_level. Clear takes priority over any update.
  always_comb begin
    max_level_d = max_level_q;
    stall_cnt_d = stall_cnt_q;
    if (io_stat_clr) begin
      max_level_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (level_d > max_level_q) max_level_d = level_d;
      if (io_push_valid && !io_push_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_level_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      max_level_q <= max_level_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign io_max_level = max_level_q;
  assign io_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cmd_fifo_sync.sv
// ---------------------------------------------------------------------------
// tb_cmd_fifo_sync
//
// Directed bench for cmd_fifo_sync at DEPTH=4, AFULL_THRESH=3. A table of
// push/pop vectors with hand-computed flags, level and head address drives
// the fill/full/stream/drain sequence; reset, exact field round-trip and
// mid-operation reset are written out by hand. Optional statistics are
// exercised when CMD_FIFO_SYNC_STAT_EN is defined.
// ---------------------------------------------------------------------------
module tb_cmd_fifo_sync;

  localparam int ADDR_W       = 27;
  localparam int BURST_W      = 6;
  localparam int DATA_W       = 128;
  localparam int MASK_W       = 16;
  localparam int DEPTH        = 4;
  localparam int AFULL_THRESH = 3;
  localparam int LVL_W        = 3;

  logic               clk = 1'b0;
  logic               rstn;
  logic               io_push_valid;
  logic               io_push_ready;
  logic               io_push_cmd_type;
  logic [ADDR_W-1:0]  io_push_addr;
  logic [BURST_W-1:0] io_push_burst_cnt;
  logic [DATA_W-1:0]  io_push_wt_data;
  logic [MASK_W-1:0]  io_push_wt_mask;
  logic               io_push_afull;
  logic               io_pop_valid;
  logic               io_pop_ready;
  logic               io_pop_cmd_type;
  logic [ADDR_W-1:0]  io_pop_addr;
  logic [BURST_W-1:0] io_pop_burst_cnt;
  logic [DATA_W-1:0]  io_pop_wt_data;
  logic [MASK_W-1:0]  io_pop_wt_mask;
  logic [LVL_W-1:0]   io_level;
`ifdef CMD_FIFO_SYNC_STAT_EN
  logic               io_stat_clr;
  logic [LVL_W-1:0]   io_max_level;
  logic [15:0]        io_stall_cnt;
`endif

  int nVectors    = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  cmd_fifo_sync #(
    .ADDR_W(ADDR_W),
    .BURST_W(BURST_W),
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .AFULL_THRESH(AFULL_THRESH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .io_push_valid(io_push_valid),
    .io_push_ready(io_push_ready),
    .io_push_cmd_type(io_push_cmd_type),
    .io_push_addr(io_push_addr),
    .io_push_burst_cnt(io_push_burst_cnt),
    .io_push_wt_data(io_push_wt_data),
    .io_push_wt_mask(io_push_wt_mask),
    .io_push_afull(io_push_afull),
    .io_pop_valid(io_pop_valid),
    .io_pop_ready(io_pop_ready),
    .io_pop_cmd_type(io_pop_cmd_type),
    .io_pop_addr(io_pop_addr),
    .io_pop_burst_cnt(io_pop_burst_cnt),
    .io_pop_wt_data(io_pop_wt_data),
    .io_pop_wt_mask(io_pop_wt_mask),
    .io_level(io_level)
`ifdef CMD_FIFO_SYNC_STAT_EN
    ,
    .io_stat_clr(io_stat_clr),
    .io_max_level(io_max_level),
    .io_stall_cnt(io_stall_cnt)
`endif
  );

  typedef struct {
    logic              pushV;
    logic              popV;
    logic [ADDR_W-1:0] addr;
    logic              expPushReady;
    logic              expPopReady;
    logic              expAfull;
    logic [LVL_W-1:0]  expLevel;
    logic [ADDR_W-1:0] expHead;
  } vec_t;

  vec_t vecs[$];

  // Payload of every table push is derived from its address, so the expected
  // head fields follow from the expected head address alone.
  function automatic logic typeOf(logic [ADDR_W-1:0] a);
    return a[0];
  endfunction

  function automatic logic [BURST_W-1:0] burstOf(logic [ADDR_W-1:0] a);
    return a[5:0] + 6'd1;
  endfunction

  function automatic logic [DATA_W-1:0] dataOf(logic [ADDR_W-1:0] a);
    return {16{a[7:0] ^ 8'h3C}};
  endfunction

  function automatic logic [MASK_W-1:0] maskOf(logic [ADDR_W-1:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  function automatic vec_t mkVec(logic pv, logic qv, logic [ADDR_W-1:0] a,
                                 logic pr, logic qr, logic af,
                                 logic [LVL_W-1:0] lv, logic [ADDR_W-1:0] hd);
    vec_t v;
    v.pushV = pv; v.popV = qv; v.addr = a;
    v.expPushReady = pr; v.expPopReady = qr; v.expAfull = af;
    v.expLevel = lv; v.expHead = hd;
    return v;
  endfunction

  task automatic applyStimulus(input logic pv, input logic qv,
                               input logic [ADDR_W-1:0] a);
    io_push_valid     = pv;
    io_pop_valid      = qv;
    io_push_cmd_type  = typeOf(a);
    io_push_addr      = a;
    io_push_burst_cnt = burstOf(a);
    io_push_wt_data   = dataOf(a);
    io_push_wt_mask   = maskOf(a);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic pr, input logic qr,
                            input logic af, input logic [LVL_W-1:0] lv,
                            input logic [ADDR_W-1:0] hd);
    checkOutput($sformatf("%s push_ready", tag), 128'(io_push_ready), 128'(pr));
    checkOutput($sformatf("%s pop_ready", tag), 128'(io_pop_ready), 128'(qr));
    checkOutput($sformatf("%s afull", tag), 128'(io_push_afull), 128'(af));
    checkOutput($sformatf("%s level", tag), 128'(io_level), 128'(lv));
    checkOutput($sformatf("%s addr", tag), 128'(io_pop_addr),
                qr ? 128'(hd) : 128'(0));
    checkOutput($sformatf("%s type", tag), 128'(io_pop_cmd_type),
                qr ? 128'(typeOf(hd)) : 128'(0));
    checkOutput($sformatf("%s burst", tag), 128'(io_pop_burst_cnt),
                qr ? 128'(burstOf(hd)) : 128'(0));
    checkOutput($sformatf("%s data", tag), io_pop_wt_data,
                qr ? dataOf(hd) : 128'(0));
    checkOutput($sformatf("%s mask", tag), 128'(io_pop_wt_mask),
                qr ? 128'(maskOf(hd)) : 128'(0));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
`ifdef CMD_FIFO_SYNC_STAT_EN
    io_stat_clr = 1'b0;
`endif

    // Fill/full/simultaneous/stream/drain table; starts from an empty queue.
    vecs.push_back(mkVec(1, 0, 27'd0, 1, 1, 0, 3'd1, 27'd0));
    vecs.push_back(mkVec(1, 0, 27'd1, 1, 1, 0, 3'd2, 27'd0));
    vecs.push_back(mkVec(1, 0, 27'd2, 1, 1, 1, 3'd3, 27'd0));
    vecs.push_back(mkVec(1, 0, 27'd3, 0, 1, 1, 3'd4, 27'd0));
    vecs.push_back(mkVec(1, 0, 27'd4, 0, 1, 1, 3'd4, 27'd0));
    vecs.push_back(mkVec(1, 1, 27'd4, 1, 1, 1, 3'd3, 27'd1));
    vecs.push_back(mkVec(1, 1, 27'd4, 1, 1, 1, 3'd3, 27'd2));
    vecs.push_back(mkVec(0, 1, 27'd0, 1, 1, 0, 3'd2, 27'd3));
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mkVec(1, 1, 27'(k + 4), 1, 1, 0, 3'd2, 27'(k + 3)));
    vecs.push_back(mkVec(0, 1, 27'd0, 1, 1, 0, 3'd1, 27'd14));
    vecs.push_back(mkVec(0, 1, 27'd0, 1, 0, 0, 3'd0, 27'd0));
    vecs.push_back(mkVec(1, 1, 27'd20, 1, 1, 0, 3'd1, 27'd20));
    vecs.push_back(mkVec(1, 0, 27'd21, 1, 1, 0, 3'd2, 27'd20));
    vecs.push_back(mkVec(1, 0, 27'd22, 1, 1, 1, 3'd3, 27'd20));

    // Reset held: both handshakes low, everything cleared.
    repeat (2) @(posedge clk);
    #1;
    checkState("reset_hold", 1'b0, 1'b0, 1'b0, 3'd0, '0);

    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkState("reset_idle", 1'b1, 1'b0, 1'b0, 3'd0, '0);

    // Exact field round-trip on the first edge after reset release.
    io_push_valid     = 1'b1;
    io_push_cmd_type  = 1'b1;
    io_push_addr      = 27'h1234567;
    io_push_burst_cnt = 6'd5;
    io_push_wt_data   = {16{8'hA5}};
    io_push_wt_mask   = 16'hFFFF;
    stepCycle();
    io_push_valid = 1'b0;
    checkOutput("rt pop_ready", 128'(io_pop_ready), 128'(1));
    checkOutput("rt level", 128'(io_level), 128'(1));
    checkOutput("rt type", 128'(io_pop_cmd_type), 128'(1));
    checkOutput("rt addr", 128'(io_pop_addr), 128'h1234567);
    checkOutput("rt burst", 128'(io_pop_burst_cnt), 128'(5));
    checkOutput("rt data", io_pop_wt_data, {16{8'hA5}});
    checkOutput("rt mask", 128'(io_pop_wt_mask), 128'hFFFF);
    applyStimulus(1'b0, 1'b1, '0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    checkState("rt_drained", 1'b1, 1'b0, 1'b0, 3'd0, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pushV, vecs[i].popV, vecs[i].addr);
      stepCycle();
      applyStimulus(1'b0, 1'b0, '0);
      checkState($sformatf("vec%0d", i), vecs[i].expPushReady,
                 vecs[i].expPopReady, vecs[i].expAfull, vecs[i].expLevel,
                 vecs[i].expHead);
    end

    // Asynchronous reset with three entries queued, away from any edge.
    #2;
    rstn = 1'b0;
    #1;
    checkState("async_reset", 1'b0, 1'b0, 1'b0, 3'd0, '0);
`ifdef CMD_FIFO_SYNC_STAT_EN
    checkOutput("async_reset max_level", 128'(io_max_level), 128'(0));
    checkOutput("async_reset stall_cnt", 128'(io_stall_cnt), 128'(0));
`endif
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkState("post_reset_idle", 1'b1, 1'b0, 1'b0, 3'd0, '0);

    applyStimulus(1'b1, 1'b0, 27'h55);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    checkState("post_reset_push", 1'b1, 1'b1, 1'b0, 3'd1, 27'h55);
    applyStimulus(1'b0, 1'b1, '0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, '0);
    checkState("post_reset_pop", 1'b1, 1'b0, 1'b0, 3'd0, '0);

`ifdef CMD_FIFO_SYNC_STAT_EN
    checkOutput("stat max_after_one", 128'(io_max_level), 128'(1));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 27'(8'h60 + k));
      stepCycle();
    end
    checkOutput("stat stall_none", 128'(io_stall_cnt), 128'(0));
    applyStimulus(1'b1, 1'b0, 27'h64);
    repeat (3) stepCycle();
    checkOutput("stat stall_three", 128'(io_stall_cnt), 128'(3));
    checkOutput("stat max_full", 128'(io_max_level), 128'(4));
    io_stat_clr = 1'b1;
    stepCycle();
    io_stat_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("stat clr_stall", 128'(io_stall_cnt), 128'(0));
    checkOutput("stat clr_max", 128'(io_max_level), 128'(0));
    stepCycle();
    checkOutput("stat max_rebuilt", 128'(io_max_level), 128'(4));
    checkOutput("stat stall_idle", 128'(io_stall_cnt), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/cmd_fifo_sync.md
Name: cmd_fifo_sync

Overview:
- Single-clock, parametrised command queue between the memory-controller front end and the DDR command scheduler.
- Each entry carries one command: type, address, burst count, write data and write mask.
- Generalises the dual-clock command FIFO:
  - widths and depth are parameters;
  - storage is inferred (no vendor FIFO IP);
  - adds an occupancy level output and an almost-full threshold so the upstream arbiter can throttle before the queue is full.

Parameters:
ADDR_W, 27, command address width
BURST_W, 6, burst count width
DATA_W, 128, write data width; must be a multiple of 8; mask width MASK_W = DATA_W/8
DEPTH, 16, entries; power of two, >= 2
AFULL_THRESH, 12, level at or above which io_push_afull asserts; 1..DEPTH

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  asynchronous active-low reset
io_push_valid  in  1  producer offers a command
io_push_ready  out  1  queue can accept; push occurs when valid && ready
io_push_cmd_type  in  1  0=read, 1=write
io_push_addr  in  ADDR_W  command address
io_push_burst_cnt  in  BURST_W  burst length
io_push_wt_data  in  DATA_W  write data
io_push_wt_mask  in  MASK_W  write byte mask
io_push_afull  out  1  level >= AFULL_THRESH
io_pop_valid  in  1  consumer requests head entry; pop occurs when valid && ready
io_pop_ready  out  1  head entry present (not empty)
io_pop_cmd_type  out  1  head command type
io_pop_addr  out  ADDR_W  head address
io_pop_burst_cnt  out  BURST_W  head burst count
io_pop_wt_data  out  DATA_W  head write data
io_pop_wt_mask  out  MASK_W  head write mask
io_level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH

Behaviour:
- Entry packing:
  - Width is 1+ADDR_W+BURST_W+DATA_W+MASK_W, MSB to LSB: cmd_type, addr, burst_cnt, wt_data, wt_mask.
  - Fields round-trip bit-exact.
- Storage:
  - DEPTH-entry circular buffer.
  - Write and read pointers are $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - Full when the index bits are equal and the wrap bits differ; empty when the pointers are equal.
  - Pointers wrap from DEPTH-1 to 0 with the wrap bit toggling.
- First-word-fall-through:
  - The io_pop_* fields show the head entry whenever io_pop_ready=1.
  - When empty, all io_pop_* data fields are driven 0.
- Handshakes and flags:
  - io_push_ready = rstn && !full.
  - io_pop_ready = rstn && !empty.
  - Neither depends combinationally on io_push_valid or io_pop_valid.
- Latency:
  - A push accepted at edge N is visible at the head, with io_pop_ready=1, after edge N when the queue was empty.
  - No same-cycle bypass.
- Simultaneous push and pop:
  - When neither full nor empty, both occur, level is unchanged, and pointers both advance.
  - When full, the push is refused (ready=0) even if a pop happens in the same cycle; level drops by 1.
  - When empty, the pop is ignored and the push proceeds.
- io_level:
  - Registered counter: +1 on push only, -1 on pop only.
  - Never exceeds DEPTH and never goes below 0.
- io_push_afull:
  - Combinational compare of io_level >= AFULL_THRESH.
- Reset:
  - Asynchronous assert clears pointers, io_level and all flags, whether or not a transfer is in progress. Any in-flight entries are discarded.
  - During reset: io_push_ready=0, io_pop_ready=0, io_push_afull=0, io_level=0, pop data fields=0.
  - Memory contents need not be cleared.
  - The first push can be accepted on the first rising edge after rstn deasserts.

Optional Feature:
- Macro: CMD_FIFO_SYNC_STAT_EN.
- When defined, three ports are added:
  - io_stat_clr (in, 1): synchronous clear of both statistics.
  - io_max_level (out, $clog2(DEPTH)+1): high-water mark of io_level since reset or clear.
  - io_stall_cnt (out, 16): counts cycles with io_push_valid && !io_push_ready while rstn=1; saturates at 0xFFFF.
- Both statistics reset to 0. If io_stat_clr and an update occur in the same cycle, the clear wins.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset then idle, DEPTH=4, AFULL_THRESH=3 -> push_ready=1, pop_ready=0, level=0, afull=0, pop fields=0.
- Push write cmd {type=1, addr=0x1234567, burst=5, data=0xA5..A5, mask=0xFFFF} into empty queue -> next cycle pop_ready=1, fields match exactly, level=1; pop -> empty, level=0.
- Push 4 entries with addr 0..3, no pops -> afull=1 at level 3, push_ready=0 at level 4; a 5th push held valid is not accepted; pop order is addr 0,1,2,3.
- Full queue with push_valid and pop_valid both high for one cycle -> only pop occurs, level 4->3; next cycle both occur, level stays 3.
- Continuous simultaneous push and pop for 10 cycles starting at level 2 -> pointers wrap past 3, level stays 2, data in FIFO order.
- rstn pulsed low with level=3 -> immediately pop_ready=0, level=0, afull=0; after release, a new push pops with the new data. With CMD_FIFO_SYNC_STAT_EN: max_level=0, stall_cnt=0 after reset, and stall_cnt increments once per stalled push cycle.
